hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage. It is the successor to the single-cycle load-use detector and adds the following:
- a scoreboard of in-flight loads, so data-memory latency is configurable;
- register-0 and operand-use qualification, so false stalls are eliminated;
- a multiply/divide busy counter gating HI/LO readers;
- branch-flush priority;
- a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_W, 5, register index width
- LOAD_LAT, 1, cycles after EX before load data is forwardable (≥1; 1 = classic one-bubble load-use)
- MDU_LAT, 4, multiply/divide occupancy in cycles (≥1)
- CNT_W, 16, stall counter width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  instruction in ID actually reads rs / rt
- id_use_hilo  in  1  instruction in ID reads HI/LO
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_mdu_start  in  1  instruction in EX starts mult/div
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  zero IF/ID contents
- idex_bubble  out  1  force ID/EX control to NOP
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Source match:
  - src_hit(r) = use & (r != 0) & (r == d).
  - Register 0 never hazards.
  - An unused operand never hazards.
- Load scoreboard:
  - pend[0..LOAD_LAT-1] holds {valid, rd} and shifts every cycle, because stages past ID never stall.
  - pend[0] is loaded with {ex_mem_read & (ex_rd != 0), ex_rd}.
- load_haz is asserted when either source hits:
  - ex_rd while ex_mem_read, or
  - any valid pend[k] with k ≤ LOAD_LAT-2.
  - With LOAD_LAT=1 only the EX check exists.
- MDU counter:
  - ex_mdu_start loads mdu_cnt = MDU_LAT-1.
  - Otherwise mdu_cnt decrements toward 0.
  - mdu_haz = id_use_hilo & (ex_mdu_start | mdu_cnt != 0).
- Output priority (combinational):
  1. ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. The flush wins over any stall because the ID instruction is wrong-path.
  2. load_haz | mdu_haz: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  3. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- stall_cycles:
  - Increments on every cycle in case 2.
  - Saturates at all-ones; it does not wrap.

## Timing
- Outputs are combinational from the current inputs plus registered state, with zero-cycle latency within the ID cycle.
- Load-use stall duration is exactly LOAD_LAT cycles for a dependent instruction directly behind the load; it is LOAD_LAT-1 cycles if one independent instruction separates them.
- A HI/LO reader immediately behind ex_mdu_start stalls MDU_LAT cycles.
- Reset is asynchronous. During and after reset:
  - all pend entries are invalid, mdu_cnt=0, stall_cycles=0;
  - outputs are pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0 unless the current EX inputs create a hit.
- Reset mid-stall drops all pending hazards immediately.
- Simultaneous ex_mdu_start and a counter nonzero: the counter reloads to MDU_LAT-1.
- Simultaneous load_haz and mdu_haz: a single stall, counted once.

## Structure
- hazard_pkg:
  - REG_W default;
  - typedef pend_entry_t {logic valid; logic [REG_W-1:0] rd};
  - function src_hit.
- Sub-module hazard_load_scoreboard:
  - contains the pend shift register and load_haz;
  - is parametrised by LOAD_LAT and REG_W.
- The top level holds the MDU counter, priority mux and stall counter.

## Test plan
- LOAD_LAT=1: load to $t1 in EX, ID reads rs=$t1 with id_use_rs=1 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1.
- Load to $0 in EX, or ID rs=$t1 with id_use_rs=0 -> no stall; outputs 1/1/0/0.
- LOAD_LAT=3: load $t2, then the dependent instruction directly behind it -> 3 stall cycles; with one independent instruction between them -> 2 stall cycles.
- ex_branch_taken=1 simultaneous with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1; stall_cycles is unchanged.
- MDU_LAT=4: ex_mdu_start, then an mfhi in ID -> 4 stall cycles; a non-HI/LO instruction in ID during busy -> no stall.
- CNT_W=4: force 20 stall cycles -> stall_cycles holds 15. Assert rst_n=0 mid-stall -> outputs return to 1/1/0/0 and the counter reads 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and helpers for the ID-stage hazard controller.
//                - c_REG_W_DEFAULT : default register index width.
//                - pend_entry_t    : {valid, rd} layout of one in-flight load
//                                    at the default register width.
//                - hz_action_t     : action chosen by the ID-stage priority mux.
//                - src_hit()       : one-operand dependency test.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int c_REG_W_DEFAULT = 5;

    typedef struct packed {
        logic                       valid;
        logic [c_REG_W_DEFAULT-1:0] rd;
    } pend_entry_t;

    typedef enum logic [1:0] {
        ACT_RUN   = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2
    } hz_action_t;

    // Register indices are passed zero-extended to 32 bits so the helper works
    // for any register width up to 32. Register 0 is hard-wired and an operand
    // the instruction does not read can never create a dependency.
    function automatic logic src_hit(input logic        use_src,
                                     input logic [31:0] src,
                                     input logic [31:0] dst);
        return use_src && (src != 32'd0) && (src == dst);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_load_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_load_scoreboard
//  Description : Tracks loads that have left EX but whose data is not yet
//                forwardable, and flags a load-use hazard for the instruction
//                in ID.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                id_rs/id_rt             - ID source registers
//                id_use_rs/id_use_rt     - ID actually reads rs / rt
//                ex_rd, ex_mem_read      - EX destination and load flag
//                load_haz                - ID must wait for a load result
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_load_scoreboard
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int REG_W    = c_REG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_haz
);

    // Entry k holds the load that was in EX k+1 cycles ago. Stages past ID
    // never stall, so the window simply shifts every cycle.
    logic [LOAD_LAT-1:0] r_valid;
    logic [REG_W-1:0]    r_rd [LOAD_LAT];

    logic w_ex_haz;
    logic w_pend_haz;
    logic w_unused_tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < LOAD_LAT; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            // Loads to $0 are dropped at entry; their result is discarded.
            r_valid[0] <= ex_mem_read & (ex_rd != '0);
            r_rd[0]    <= ex_rd;
            for (int k = 1; k < LOAD_LAT; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
        end
    end

    assign w_ex_haz = ex_mem_read &
                      (src_hit(id_use_rs, 32'(id_rs), 32'(ex_rd)) |
                       src_hit(id_use_rt, 32'(id_rt), 32'(ex_rd)));

    // Only entries 0..LOAD_LAT-2 are still short of forwardable; the deepest
    // entry completes the window and its data is available this cycle.
    always_comb begin
        w_pend_haz = 1'b0;
        for (int k = 0; k < LOAD_LAT - 1; k++) begin
            if (r_valid[k] &&
                (src_hit(id_use_rs, 32'(id_rs), 32'(r_rd[k])) ||
                 src_hit(id_use_rt, 32'(id_rt), 32'(r_rd[k])))) begin
                w_pend_haz = 1'b1;
            end
        end
    end

    // The deepest entry never participates in a compare.
    assign w_unused_tail = r_valid[LOAD_LAT-1] | (|r_rd[LOAD_LAT-1]);

    assign load_haz = w_ex_haz | w_pend_haz;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : ID-stage hazard controller for the 5-stage MIPS core.
//                Combines load-use detection (via hazard_load_scoreboard),
//                a multiply/divide busy counter gating HI/LO readers,
//                branch-flush priority and a saturating stall counter.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                id_rs, id_rt, id_use_rs,
//                id_use_rt, id_use_hilo      - ID operand usage
//                ex_rd, ex_mem_read,
//                ex_mdu_start, ex_branch_taken - EX stage status
//                pc_write, ifid_write        - front-end enables
//                ifid_flush, idex_bubble     - squash controls
//                stall_cycles                - saturating stall-cycle count
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = c_REG_W_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_hilo,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_mdu_start,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int                 c_MDU_W      = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [c_MDU_W-1:0] c_MDU_RELOAD = c_MDU_W'(MDU_LAT - 1);

    logic               w_load_haz;
    logic               w_mdu_haz;
    hz_action_t         w_action;
    logic [c_MDU_W-1:0] r_mdu_cnt;
    logic [CNT_W-1:0]   r_stall_cycles;

    hazard_load_scoreboard #(
        .LOAD_LAT (LOAD_LAT),
        .REG_W    (REG_W)
    ) u_load_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_haz    (w_load_haz)
    );

    // The cycle of ex_mdu_start counts as the first busy cycle, so the counter
    // only needs to cover the remaining MDU_LAT-1. A new start always reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_cnt <= '0;
        end else if (ex_mdu_start) begin
            r_mdu_cnt <= c_MDU_RELOAD;
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt <= r_mdu_cnt - c_MDU_W'(1);
        end
    end

    assign w_mdu_haz = id_use_hilo & (ex_mdu_start | (r_mdu_cnt != '0));

    // A taken branch makes the ID instruction wrong-path, so the flush
    // overrides any stall it might otherwise have caused.
    always_comb begin
        w_action = ACT_RUN;
        if (ex_branch_taken) begin
            w_action = ACT_FLUSH;
        end else if (w_load_haz | w_mdu_haz) begin
            w_action = ACT_STALL;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (w_action)
            ACT_FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            ACT_STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if ((w_action == ACT_STALL) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Two instances share the
//                stimulus: A (LOAD_LAT=1, MDU_LAT=4, CNT_W=4) and
//                B (LOAD_LAT=3, MDU_LAT=4, CNT_W=16). The reference model
//                remembers the cycle of the latest load per register and of
//                the latest mult/div start, and derives stalls from ages.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MDU   = 4;
    localparam int CW_A  = 4;
    localparam int CW_B  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_use_rs, id_use_rt, id_use_hilo;
    logic ex_mem_read, ex_mdu_start, ex_branch_taken;

    logic pc_a, ifw_a, fl_a, bub_a;
    logic pc_b, ifw_b, fl_b, bub_b;
    logic [CW_A-1:0] sc_a;
    logic [CW_B-1:0] sc_b;
    logic [3:0] ctrl_a, ctrl_b;

    assign ctrl_a = {pc_a, ifw_a, fl_a, bub_a};
    assign ctrl_b = {pc_b, ifw_b, fl_b, bub_b};

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(LAT_A), .MDU_LAT(MDU), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_hilo(id_use_hilo),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_a), .ifid_write(ifw_a),
        .ifid_flush(fl_a), .idex_bubble(bub_a), .stall_cycles(sc_a));

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(LAT_B), .MDU_LAT(MDU), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_hilo(id_use_hilo),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_b), .ifid_write(ifw_b),
        .ifid_flush(fl_b), .idex_bubble(bub_b), .stall_cycles(sc_b));

    // ---------------- reference model ----------------
    int cyc;
    int last_load [32];
    int last_mdu;
    int cnt_a, cnt_b;
    int tests, fails;

    task automatic model_reset();
        for (int r = 0; r < 32; r++) last_load[r] = -1000;
        last_mdu = -1000;
        cnt_a    = 0;
        cnt_b    = 0;
    endtask

    // Age of the newest load to r; a load currently in EX has age 0.
    function automatic int load_age(logic [4:0] r);
        if (ex_mem_read && ex_rd == r) return 0;
        return cyc - last_load[r];
    endfunction

    function automatic bit m_stall(int lat);
        bit ld = (id_use_rs && id_rs != 5'd0 && load_age(id_rs) < lat) ||
                 (id_use_rt && id_rt != 5'd0 && load_age(id_rt) < lat);
        bit md = id_use_hilo && (ex_mdu_start || (cyc - last_mdu) < MDU);
        return ld || md;
    endfunction

    function automatic logic [3:0] m_ctrl(int lat);
        if (ex_branch_taken) return 4'b1111;
        if (m_stall(lat))    return 4'b0001;
        return 4'b1100;
    endfunction

    task automatic tick();
        if (rst_n) begin
            if (!ex_branch_taken && m_stall(LAT_A) && cnt_a < (1 << CW_A) - 1) cnt_a++;
            if (!ex_branch_taken && m_stall(LAT_B) && cnt_b < (1 << CW_B) - 1) cnt_b++;
            if (ex_mem_read)  last_load[ex_rd] = cyc;
            if (ex_mdu_start) last_mdu = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt, input logic uhl, input logic [4:0] rd,
                         input logic mr, input logic ms, input logic br);
        id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt; id_use_hilo = uhl;
        ex_rd = rd; ex_mem_read = mr; ex_mdu_start = ms; ex_branch_taken = br;
    endtask

    task automatic idle(int n);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        tests++; if (ctrl_a !== 4'b1100) begin fails++; $display("FAIL reset_ctrl_a got=%b want=1100", ctrl_a); end
        tests++; if (ctrl_b !== 4'b1100) begin fails++; $display("FAIL reset_ctrl_b got=%b want=1100", ctrl_b); end
        tests++; if (sc_a !== '0) begin fails++; $display("FAIL reset_cnt_a got=%0d want=0", sc_a); end
        tests++; if (sc_b !== '0) begin fails++; $display("FAIL reset_cnt_b got=%0d want=0", sc_b); end
        // A hit from the current EX inputs is visible even while in reset.
        drive(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        tests++; if (ctrl_a !== 4'b0001) begin fails++; $display("FAIL reset_exhit_a got=%b want=0001", ctrl_a); end
        tests++; if (ctrl_b !== 4'b0001) begin fails++; $display("FAIL reset_exhit_b got=%b want=0001", ctrl_b); end
        @(posedge clk);
        @(negedge clk);
        tests++; if (sc_a !== '0 || sc_b !== '0) begin fails++; $display("FAIL reset_hold_cnt got=%0d/%0d want=0/0", sc_a, sc_b); end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            drive(5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, (i == 0), 1'b0, 1'b0);
            #1;
            tests++; if (ctrl_a !== m_ctrl(LAT_A)) begin fails++; $display("FAIL loaduse_a cyc=%0d got=%b want=%b", cyc, ctrl_a, m_ctrl(LAT_A)); end
            tests++; if (ctrl_b !== m_ctrl(LAT_B)) begin fails++; $display("FAIL loaduse_b cyc=%0d got=%b want=%b", cyc, ctrl_b, m_ctrl(LAT_B)); end
            tick();
        end
        tests++; if (sc_a !== 4'd1) begin fails++; $display("FAIL loaduse_cnt_a got=%0d want=1", sc_a); end
        tests++; if (sc_b !== 16'd3) begin fails++; $display("FAIL loaduse_cnt_b got=%0d want=3", sc_b); end
    endtask

    task automatic test_no_false_stall();
        drive(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #1;
        tests++; if (ctrl_a !== 4'b1100 || ctrl_b !== 4'b1100) begin fails++; $display("FAIL reg0_load got=%b/%b want=1100", ctrl_a, ctrl_b); end
        tick();
        drive(5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        tests++; if (ctrl_a !== 4'b1100 || ctrl_b !== 4'b1100) begin fails++; $display("FAIL unused_operand got=%b/%b want=1100", ctrl_a, ctrl_b); end
        tick();
        // Unused operands must not hit the pending entry either.
        drive(5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        tests++; if (ctrl_b !== 4'b1100) begin fails++; $display("FAIL unused_pend_b got=%b want=1100", ctrl_b); end
        tick();
        idle(4);
    endtask

    task automatic test_lat3_window();
        int n;
        for (int gap = 0; gap < 2; gap++) begin
            n = 0;
            if (gap == 1) begin
                drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
                #1;
                tests++; if (ctrl_b !== 4'b1100) begin fails++; $display("FAIL gap_indep_b got=%b want=1100", ctrl_b); end
                tick();
            end
            for (int i = 0; i < 8; i++) begin
                if (gap == 0 && i == 0) drive(5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
                else if (gap == 1 && i == 0) drive(5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
                else drive(5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
                #1;
                tests++; if (ctrl_b !== m_ctrl(LAT_B)) begin fails++; $display("FAIL lat3_b gap=%0d cyc=%0d got=%b want=%b", gap, cyc, ctrl_b, m_ctrl(LAT_B)); end
                tests++; if (ctrl_a !== m_ctrl(LAT_A)) begin fails++; $display("FAIL lat3_a gap=%0d cyc=%0d got=%b want=%b", gap, cyc, ctrl_a, m_ctrl(LAT_A)); end
                if (ctrl_b !== 4'b0001) break;
                n++;
                tick();
            end
            tick();
            tests++; if (n != 3 - gap) begin fails++; $display("FAIL lat3_stall_len gap=%0d got=%0d want=%0d", gap, n, 3 - gap); end
            tests++; if (sc_b !== CW_B'(cnt_b)) begin fails++; $display("FAIL lat3_cnt_b got=%0d want=%0d", sc_b, cnt_b); end
            idle(4);
        end
    endtask

    task automatic test_branch();
        drive(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
        #1;
        tests++; if (ctrl_a !== 4'b1111) begin fails++; $display("FAIL branch_a got=%b want=1111", ctrl_a); end
        tests++; if (ctrl_b !== 4'b1111) begin fails++; $display("FAIL branch_b got=%b want=1111", ctrl_b); end
        tick();
        #1;
        tests++; if (sc_a !== CW_A'(cnt_a)) begin fails++; $display("FAIL branch_cnt_a got=%0d want=%0d", sc_a, cnt_a); end
        tests++; if (sc_b !== CW_B'(cnt_b)) begin fails++; $display("FAIL branch_cnt_b got=%0d want=%0d", sc_b, cnt_b); end
        idle(5);
    endtask

    task automatic test_mdu();
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, (i == 0), 1'b0);
            #1;
            tests++; if (ctrl_a !== m_ctrl(LAT_A)) begin fails++; $display("FAIL mdu_a cyc=%0d got=%b want=%b", cyc, ctrl_a, m_ctrl(LAT_A)); end
            if (ctrl_a !== 4'b0001) break;
            n++;
            tick();
        end
        tick();
        tests++; if (n != MDU) begin fails++; $display("FAIL mdu_stall_len got=%0d want=%0d", n, MDU); end
        for (int i = 0; i < MDU; i++) begin
            drive(5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd7, 1'b0, (i == 0), 1'b0);
            #1;
            tests++; if (ctrl_a !== 4'b1100 || ctrl_b !== 4'b1100) begin fails++; $display("FAIL mdu_nonhilo i=%0d got=%b/%b want=1100", i, ctrl_a, ctrl_b); end
            tick();
        end
        idle(MDU);
    endtask

    task automatic test_saturation_and_reset();
        for (int i = 0; i < 20; i++) begin
            drive(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
            tick();
        end
        #1;
        tests++; if (sc_a !== 4'd15) begin fails++; $display("FAIL sat_cnt_a got=%0d want=15", sc_a); end
        tests++; if (sc_b !== CW_B'(cnt_b)) begin fails++; $display("FAIL sat_cnt_b got=%0d want=%0d", sc_b, cnt_b); end
        // Hazard now comes only from registered state (busy MDU, pending load).
        drive(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        tests++; if (ctrl_a !== 4'b0001 || ctrl_b !== 4'b0001) begin fails++; $display("FAIL prereset_stall got=%b/%b want=0001", ctrl_a, ctrl_b); end
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (ctrl_a !== 4'b1100 || ctrl_b !== 4'b1100) begin fails++; $display("FAIL midreset_ctrl got=%b/%b want=1100", ctrl_a, ctrl_b); end
        tests++; if (sc_a !== '0 || sc_b !== '0) begin fails++; $display("FAIL midreset_cnt got=%0d/%0d want=0/0", sc_a, sc_b); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cyc++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            #1;
            tests++; if (ctrl_a !== m_ctrl(LAT_A)) begin fails++; $display("FAIL rand_ctrl_a cyc=%0d got=%b want=%b", cyc, ctrl_a, m_ctrl(LAT_A)); end
            tests++; if (ctrl_b !== m_ctrl(LAT_B)) begin fails++; $display("FAIL rand_ctrl_b cyc=%0d got=%b want=%b", cyc, ctrl_b, m_ctrl(LAT_B)); end
            tests++; if (sc_a !== CW_A'(cnt_a)) begin fails++; $display("FAIL rand_cnt_a cyc=%0d got=%0d want=%0d", cyc, sc_a, cnt_a); end
            tests++; if (sc_b !== CW_B'(cnt_b)) begin fails++; $display("FAIL rand_cnt_b cyc=%0d got=%0d want=%0d", cyc, sc_b, cnt_b); end
            tick();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_lat3_window();
        test_branch();
        test_mdu();
        test_saturation_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
